// File: rtl/operand_stream_tx.sv
// operand_stream_tx: streams paired a/b operand words from two sync-read memories to the chip
module operand_stream_tx #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int LEN_WIDTH = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    a_base,
    input  logic [ADDR_WIDTH-1:0]    b_base,
    input  logic [LEN_WIDTH-1:0]     length,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_WIDTH-1:0]    a_mem_read_addr,
    output logic                     a_mem_read_en,
    input  logic [IO_DATA_WIDTH-1:0] a_mem_qout,
    output logic [ADDR_WIDTH-1:0]    b_mem_read_addr,
    output logic                     b_mem_read_en,
    input  logic [IO_DATA_WIDTH-1:0] b_mem_qout,
    output logic [IO_DATA_WIDTH-1:0] a_input,
    output logic                     a_valid,
    output logic [IO_DATA_WIDTH-1:0] b_input,
    output logic                     b_valid,
    input  logic                     a_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                         state, state_next;
    logic [ADDR_WIDTH-1:0]          a_base_r, b_base_r;
    logic [LEN_WIDTH-1:0]           len_r, issued_cnt, popped_cnt;
    logic                           inflight;
    logic [2*IO_DATA_WIDTH-1:0]     fifo [FIFO_DEPTH];
    logic [2*IO_DATA_WIDTH-1:0]     head;
    logic [PW-1:0]                  wr_ptr, rd_ptr;
    logic [CW-1:0]                  count;
    logic                           issue, pop, last_issue, last_pop;

    assign a_valid = count != '0;
    assign b_valid = a_valid;
    assign pop = a_valid & a_ready;
    assign head = fifo[rd_ptr];
    assign a_input = a_valid ? head[2*IO_DATA_WIDTH-1:IO_DATA_WIDTH] : '0;
    assign b_input = a_valid ? head[IO_DATA_WIDTH-1:0] : '0;
    assign last_issue = issued_cnt == len_r - LEN_WIDTH'(1);
    assign last_pop = pop && popped_cnt == len_r - LEN_WIDTH'(1);
    assign a_mem_read_en = issue;
    assign b_mem_read_en = issue;
    assign a_mem_read_addr = issue ? a_base_r + ADDR_WIDTH'(issued_cnt) : '0;
    assign b_mem_read_addr = issue ? b_base_r + ADDR_WIDTH'(issued_cnt) : '0;

    // State register
    always_ff @(posedge clk) begin
        if (!arst_n_in) state <= IDLE;
        else state <= state_next;
    end

    // Next state, status outputs and read issue; a read only goes out if its data is sure to find a FIFO slot
    always_comb begin
        state_next = state;
        busy = 1'b0;
        done = 1'b0;
        issue = 1'b0;
        case (state)
            IDLE: if (start) state_next = (length == '0) ? DONE : STREAM;
            STREAM: begin
                busy = 1'b1;
                issue = issued_cnt < len_r && (int'(count) + int'(inflight) < FIFO_DEPTH + int'(pop));
                if (issue && last_issue) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_pop) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latch, transfer counters, in-flight flag and FIFO pointers
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            a_base_r <= '0;
            b_base_r <= '0;
            len_r <= '0;
            issued_cnt <= '0;
            popped_cnt <= '0;
            inflight <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (state == IDLE && start) begin
                a_base_r <= a_base;
                b_base_r <= b_base;
                len_r <= length;
                issued_cnt <= '0;
                popped_cnt <= '0;
            end else begin
                if (issue) issued_cnt <= issued_cnt + LEN_WIDTH'(1);
                if (pop) popped_cnt <= popped_cnt + LEN_WIDTH'(1);
            end
            inflight <= issue;
            if (inflight) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(inflight) - CW'(pop);
        end
    end

    // Returning memory data lands in the FIFO as one {a,b} pair
    always_ff @(posedge clk) begin
        if (inflight) fifo[wr_ptr] <= {a_mem_qout, b_mem_qout};
    end
endmodule

// File: tb/tb_operand_stream_tx.sv
// tb_operand_stream_tx: randomized self-checking bench for operand_stream_tx
module tb_operand_stream_tx;
    localparam int DW = 16;
    localparam int AW = 20;
    localparam int LW = 16;

    logic          clk, arst_n_in, start, busy, done, a_ready;
    logic [AW-1:0] a_base, b_base, a_mem_read_addr, b_mem_read_addr;
    logic [LW-1:0] length;
    logic          a_mem_read_en, b_mem_read_en, a_valid, b_valid;
    logic [DW-1:0] a_mem_qout, b_mem_qout, a_input, b_input;

    operand_stream_tx #(.IO_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(2)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .a_base(a_base), .b_base(b_base),
        .length(length), .busy(busy), .done(done),
        .a_mem_read_addr(a_mem_read_addr), .a_mem_read_en(a_mem_read_en), .a_mem_qout(a_mem_qout),
        .b_mem_read_addr(b_mem_read_addr), .b_mem_read_en(b_mem_read_en), .b_mem_qout(b_mem_qout),
        .a_input(a_input), .a_valid(a_valid), .b_input(b_input), .b_valid(b_valid), .a_ready(a_ready)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    logic [DW-1:0] a_off = '0;
    logic [DW-1:0] b_off = '0;

    logic [31:0]   pop_q[$];
    int            pop_cyc[$];
    int            done_cyc[$];
    logic [AW-1:0] ra_q[$];
    logic [AW-1:0] rb_q[$];
    int            busy_cnt, first_valid, unstable, max_out, lane_mis;
    bit            prev_hold;
    logic [DW-1:0] prev_a, prev_b;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word value is a lane offset plus the low address bits, one cycle read latency
    always @(posedge clk) begin
        if (a_mem_read_en) a_mem_qout <= a_off + a_mem_read_addr[DW-1:0];
        if (b_mem_read_en) b_mem_qout <= b_off + b_mem_read_addr[DW-1:0];
    end

    // Observer: records pops, reads, done pulses and protocol properties away from the clock edge
    always @(negedge clk) begin
        if (a_valid !== b_valid) lane_mis++;
        if (prev_hold && (!a_valid || a_input !== prev_a || b_input !== prev_b)) unstable++;
        prev_hold = a_valid && !a_ready;
        prev_a = a_input;
        prev_b = b_input;
        if (ra_q.size() - pop_q.size() > max_out) max_out = ra_q.size() - pop_q.size();
        if (a_valid && first_valid < 0) first_valid = cyc - t0;
        if (a_valid && a_ready) begin
            pop_q.push_back({a_input, b_input});
            pop_cyc.push_back(cyc - t0);
        end
        if (a_mem_read_en) ra_q.push_back(a_mem_read_addr);
        if (b_mem_read_en) rb_q.push_back(b_mem_read_addr);
        if (done) done_cyc.push_back(cyc - t0);
        if (busy) busy_cnt++;
    end

    function automatic logic [31:0] exp_pair(input logic [AW-1:0] ab, input logic [AW-1:0] bb, input int i);
        logic [AW-1:0] aa, ba;
        aa = ab + AW'(i);
        ba = bb + AW'(i);
        return {a_off + aa[DW-1:0], b_off + ba[DW-1:0]};
    endfunction

    task automatic clear_log();
        pop_q = {};
        pop_cyc = {};
        done_cyc = {};
        ra_q = {};
        rb_q = {};
        busy_cnt = 0;
        first_valid = -1;
        unstable = 0;
        max_out = 0;
        lane_mis = 0;
        prev_hold = 0;
    endtask

    task automatic issue_start(input logic [AW-1:0] ab, input logic [AW-1:0] bb, input logic [LW-1:0] len);
        @(posedge clk); #1;
        start = 1;
        a_base = ab;
        b_base = bb;
        length = len;
        t0 = cyc;
        clear_log();
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic run(input int mode, input int maxc);
        bit seen = 0;
        for (int k = 0; k < maxc && !seen; k++) begin
            a_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc - t0) % 3 == 0) : ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            seen = done_cyc.size() != 0;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL timeout: no done after %0d cycles", maxc); end
        a_ready = 1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n_in = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, a_mem_read_en, b_mem_read_en, a_valid, b_valid, a_mem_read_addr, b_mem_read_addr, a_input, b_input} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: busy=%b done=%b valid=%b rd_en=%b want all 0", busy, done, a_valid, a_mem_read_en);
        end
        arst_n_in = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        a_off = 16'h100; b_off = 16'h200; a_ready = 1;
        issue_start(0, 0, 4);
        run(0, 40);
        n_checks++; if (first_valid !== 3) begin n_fail++; $display("FAIL basic_first_valid: got %0d want 3", first_valid); end
        n_checks++; if (pop_q.size() !== 4) begin n_fail++; $display("FAIL basic_pops: got %0d want 4", pop_q.size()); end
        for (int i = 0; i < 4 && i < pop_q.size(); i++) begin
            n_checks++;
            if (pop_q[i] !== {16'h100 + 16'(i), 16'h200 + 16'(i)}) begin
                n_fail++; $display("FAIL basic_pair%0d: got %h want %h", i, pop_q[i], {16'h100 + 16'(i), 16'h200 + 16'(i)});
            end
        end
        n_checks++; if (pop_cyc.size() != 4 || pop_cyc[0] !== 3 || pop_cyc[3] !== 6) begin n_fail++; $display("FAIL basic_pop_cycles: got %p want 3..6", pop_cyc); end
        n_checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 7) begin n_fail++; $display("FAIL basic_done: got %p want {7}", done_cyc); end
        n_checks++; if (ra_q.size() !== 4 || rb_q.size() !== 4) begin n_fail++; $display("FAIL basic_reads: got a=%0d b=%0d want 4", ra_q.size(), rb_q.size()); end
        n_checks++; if (busy_cnt !== 6) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 6", busy_cnt); end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] ab, bb;
        int errs = 0;
        ab = AW'($urandom); bb = AW'($urandom);
        a_off = 16'($urandom); b_off = 16'($urandom);
        a_ready = 1;
        issue_start(ab, bb, 6);
        run(1, 80);
        n_checks++; if (pop_q.size() !== 6) begin n_fail++; $display("FAIL bp_pops: got %0d want 6", pop_q.size()); end
        for (int i = 0; i < 6 && i < pop_q.size(); i++) if (pop_q[i] !== exp_pair(ab, bb, i)) errs++;
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL bp_pairs: got %0d wrong pairs want 0", errs); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable holds want 0", unstable); end
        n_checks++; if (max_out > 2) begin n_fail++; $display("FAIL bp_occupancy: got %0d want <=2", max_out); end
        n_checks++; if (lane_mis !== 0) begin n_fail++; $display("FAIL bp_lane_valid: got %0d mismatches want 0", lane_mis); end
        n_checks++; if (done_cyc.size() !== 1 || pop_cyc.size() == 0 || done_cyc[0] !== pop_cyc[pop_cyc.size()-1] + 1) begin
            n_fail++; $display("FAIL bp_done: got %p want one pulse after last pop %p", done_cyc, pop_cyc);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            logic [AW-1:0] ab, bb;
            int len, errs;
            ab = AW'($urandom); bb = AW'($urandom);
            a_off = 16'($urandom); b_off = 16'($urandom);
            len = $urandom_range(1, 20);
            errs = 0;
            issue_start(ab, bb, LW'(len));
            run(2, 400);
            if (pop_q.size() != len) errs++;
            for (int i = 0; i < len && i < pop_q.size(); i++) if (pop_q[i] !== exp_pair(ab, bb, i)) errs++;
            for (int i = 0; i < len && i < ra_q.size() && i < rb_q.size(); i++)
                if (ra_q[i] !== ab + AW'(i) || rb_q[i] !== bb + AW'(i)) errs++;
            if (unstable != 0 || max_out > 2 || done_cyc.size() != 1) errs++;
            n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL random%0d: got %0d errors (len=%0d pops=%0d dones=%0d) want 0", t, errs, len, pop_q.size(), done_cyc.size()); end
        end
    endtask

    task automatic test_zero_length();
        a_ready = 1;
        issue_start(20'h123, 20'h456, 0);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 1) begin n_fail++; $display("FAIL zero_done: got %p want {1}", done_cyc); end
        n_checks++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_cnt); end
        n_checks++; if (ra_q.size() + rb_q.size() !== 0) begin n_fail++; $display("FAIL zero_reads: got %0d want 0", ra_q.size() + rb_q.size()); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] wa[4];
        wa = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
        a_off = 16'h0; b_off = 16'h5000; a_ready = 1;
        issue_start(20'hFFFFE, 20'hFFFFF, 4);
        run(0, 40);
        n_checks++; if (ra_q.size() !== 4) begin n_fail++; $display("FAIL wrap_reads: got %0d want 4", ra_q.size()); end
        for (int i = 0; i < 4 && i < ra_q.size(); i++) begin
            n_checks++; if (ra_q[i] !== wa[i]) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, ra_q[i], wa[i]); end
        end
        n_checks++; if (pop_q.size() !== 4 || pop_q[3] !== exp_pair(20'hFFFFE, 20'hFFFFF, 3)) begin n_fail++; $display("FAIL wrap_last_pair: got %p", pop_q); end
    endtask

    task automatic test_start_busy();
        int errs = 0;
        a_off = 16'h1111; b_off = 16'h2222; a_ready = 1;
        issue_start(20'h00040, 20'h00080, 5);
        start = 1; a_base = 20'h00900; b_base = 20'h00A00; length = 3;
        @(posedge clk); #1;
        start = 0;
        run(0, 40);
        for (int i = 0; i < 5 && i < pop_q.size(); i++) if (pop_q[i] !== exp_pair(20'h00040, 20'h00080, i)) errs++;
        n_checks++; if (pop_q.size() !== 5 || errs !== 0) begin n_fail++; $display("FAIL busy_start_pairs: got %0d pops %0d wrong want 5,0", pop_q.size(), errs); end
        n_checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 8) begin n_fail++; $display("FAIL busy_start_done: got %p want {8}", done_cyc); end
        n_checks++; if (ra_q.size() !== 5) begin n_fail++; $display("FAIL busy_start_reads: got %0d want 5", ra_q.size()); end
    endtask

    task automatic test_reset_mid();
        int nd, nr, errs;
        a_off = 16'h3000; b_off = 16'h4000; a_ready = 1;
        issue_start(20'h00100, 20'h00200, 8);
        for (int k = 0; k < 50 && pop_q.size() < 2; k++) begin @(posedge clk); #1; end
        arst_n_in = 0;
        @(posedge clk); #1;
        arst_n_in = 1;
        n_checks++;
        if ({busy, done, a_mem_read_en, b_mem_read_en, a_valid, b_valid, a_mem_read_addr, b_mem_read_addr, a_input, b_input} !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: busy=%b done=%b valid=%b rd_en=%b want all 0", busy, done, a_valid, a_mem_read_en);
        end
        nd = done_cyc.size(); nr = ra_q.size();
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (done_cyc.size() !== nd || ra_q.size() !== nr) begin n_fail++; $display("FAIL midreset_idle: got %0d dones %0d reads want none", done_cyc.size() - nd, ra_q.size() - nr); end
        issue_start(20'h07000, 20'h08000, 5);
        run(0, 40);
        errs = 0;
        for (int i = 0; i < 5 && i < pop_q.size(); i++) if (pop_q[i] !== exp_pair(20'h07000, 20'h08000, i)) errs++;
        n_checks++; if (pop_q.size() !== 5 || errs !== 0) begin n_fail++; $display("FAIL midreset_restart: got %0d pops %0d wrong want 5,0", pop_q.size(), errs); end
        n_checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 8) begin n_fail++; $display("FAIL midreset_done: got %p want {8}", done_cyc); end
    endtask

    initial begin
        start = 0; a_ready = 1; arst_n_in = 0;
        a_base = '0; b_base = '0; length = '0;
        clear_log();
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_zero_length();
        test_wrap();
        test_start_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
